// File: rtl/primitive_sr_bram_vtap.sv
// primitive_sr_bram_vtap
// Circular delay line held in block RAM, with a tap distance chosen at run
// time plus a fixed tap at the full buffer length. After reset a sweep
// writes zero to every word, so the buffer never returns stale data.
//
// Ports:
//   i_EMUCLK  master clock, all state changes on the rising edge
//   i_RST     synchronous reset, active high; restarts the clear sweep
//   i_CEN_n   active-low enable for shift/read activity
//   i_WR      write the current slot (otherwise the slot recirculates)
//   i_TAP     requested delay in enabled cycles (0 -> 1, >LENGTH -> LENGTH)
//   i_D       write data
//   o_Q_TAP   registered word at the requested delay
//   o_Q_LAST  registered word at delay LENGTH
//   o_PTR     current write pointer
//   o_BUSY    high while the clear sweep runs
//
// Enable semantics: an edge with i_CEN_n=0 in RUN is one transfer slot.
// There is no back-pressure; outputs hold between enabled edges.
module primitive_sr_bram_vtap #(
  parameter int WIDTH  = 8,
  parameter int LENGTH = 32,
  localparam int PTRW  = $clog2(LENGTH)
) (
  input  logic             i_EMUCLK,
  input  logic             i_RST,
  input  logic             i_CEN_n,
  input  logic             i_WR,
  input  logic [PTRW:0]    i_TAP,
  input  logic [WIDTH-1:0] i_D,
  output logic [WIDTH-1:0] o_Q_TAP,
  output logic [WIDTH-1:0] o_Q_LAST,
  output logic [PTRW-1:0]  o_PTR,
  output logic             o_BUSY
);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam logic [PTRW-1:0] LAST  = PTRW'(LENGTH - 1);
  localparam logic [PTRW:0]   LEN_X = (PTRW + 1)'(LENGTH);

  state_t           state_q;
  state_t           state_d;
  logic [PTRW-1:0]  clraddr;
  logic [PTRW-1:0]  wrptr;
  logic [PTRW-1:0]  rdaddr;
  logic [PTRW-1:0]  waddr;
  logic [PTRW:0]    teff;
  logic [PTRW:0]    wrptr_x;
  logic             run_en;
  logic             we;
  logic [WIDTH-1:0] wdata;

  // Two identical copies give two synchronous read ports; both always see
  // the same writes.
  logic [WIDTH-1:0] mem_tap  [LENGTH];
  logic [WIDTH-1:0] mem_last [LENGTH];

  // ---------------- FSM ----------------
  always_ff @(posedge i_EMUCLK) begin
    if (i_RST) state_q <= CLEAR;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR:   if (clraddr == LAST) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = CLEAR;
    endcase
  end

  // ---------------- control ----------------
  assign run_en = (state_q == RUN) && !i_CEN_n;

  // Clear sweep writes zero regardless of the enable and write inputs.
  assign we    = !i_RST && ((state_q == CLEAR) || (run_en && i_WR));
  assign waddr = (state_q == CLEAR) ? clraddr : wrptr;
  assign wdata = (state_q == CLEAR) ? '0 : i_D;

  always_comb begin
    teff = i_TAP;
    if (i_TAP == '0)        teff = (PTRW + 1)'(1);
    else if (i_TAP > LEN_X) teff = LEN_X;
  end

  // Read address = (wrptr - teff) mod LENGTH, valid for non-power-of-two
  // LENGTH as well. teff == LENGTH lands on wrptr itself, and the read
  // sees the old word because reads and writes share the edge.
  assign wrptr_x = {1'b0, wrptr};
  assign rdaddr  = (teff > wrptr_x) ? PTRW'(wrptr_x + LEN_X - teff)
                                    : PTRW'(wrptr_x - teff);

  always_ff @(posedge i_EMUCLK) begin
    if (i_RST) begin
      clraddr <= '0;
      wrptr   <= '0;
    end else if (state_q == CLEAR) begin
      clraddr <= clraddr + 1'b1;
    end else if (run_en) begin
      wrptr <= (wrptr == LAST) ? '0 : wrptr + 1'b1;
    end
  end

  // ---------------- storage ----------------
  always_ff @(posedge i_EMUCLK) begin
    if (we) begin
      mem_tap[waddr]  <= wdata;
      mem_last[waddr] <= wdata;
    end
  end

  always_ff @(posedge i_EMUCLK) begin
    if (i_RST) begin
      o_Q_TAP  <= '0;
      o_Q_LAST <= '0;
    end else if (run_en) begin
      o_Q_TAP  <= mem_tap[rdaddr];
      o_Q_LAST <= mem_last[wrptr];
    end
  end

  assign o_PTR  = wrptr;
  assign o_BUSY = (state_q == CLEAR);

endmodule
